eight_bit_div_module: RTL and testbench

//  Sequential unsigned integer divider: the inverse of the 8-bit combinational multiplier.

---
 rtl/eight_bit_div_module_pkg.sv | 16 +
 rtl/eight_bit_div_module_sub_step.sv | 23 ++
 rtl/eight_bit_div_module.sv | 97 +++++++++
 tb/tb_eight_bit_div_module.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/eight_bit_div_module_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default operand width and the divide-by-zero quotient fill.
package eight_bit_div_module_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Every quotient bit takes this value on a divide by zero (all ones).
  localparam logic DBZ_FILL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : eight_bit_div_module_pkg

// File: rtl/eight_bit_div_module_sub_step.sv
// One radix-2 restoring step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep the difference if no borrow.
module div_sub_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_w,
  input  logic             quo_msb,
  input  logic [WIDTH-1:0] div_w,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The partial remainder stays below the divisor, so shifted < 2*div and
  // the top bit of the difference is exactly the borrow.
  assign shifted  = {rem_w, quo_msb};
  assign diff     = shifted - {1'b0, div_w};
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule : div_sub_step

// File: rtl/eight_bit_div_module.sv
// Sequential unsigned divider: WIDTH-cycle restoring shift-subtract with a
// start/busy/done handshake and a divide-by-zero short cut.
module eight_bit_div_module
  import eight_bit_div_module_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t           state;
  // The restore path never sets the extra remainder bit, so only the low
  // WIDTH bits of the partial remainder are stored.
  logic [WIDTH-1:0] rem_w;
  logic [WIDTH-1:0] quo_w;
  logic [WIDTH-1:0] div_w;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] rem_next;
  logic             q_bit;

  div_sub_step #(.WIDTH(WIDTH)) u_step (
    .rem_w    (rem_w),
    .quo_msb  (quo_w[WIDTH-1]),
    .div_w    (div_w),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // NOTE: state uses non-blocking assignments so every register in this
  // block samples the pre-edge values; blocking here would chain the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: work registers are reset too, so an abandoned divide leaves
      // no stale partial result behind; they are flops, not a memory array.
      state       <= ST_IDLE;
      rem_w       <= '0;
      quo_w       <= '0;
      div_w       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (b == '0) begin
              quotient    <= {WIDTH{DBZ_FILL}};
              remainder   <= a;
              div_by_zero <= 1'b1;
              state       <= ST_DONE;
            end else begin
              rem_w <= '0;
              quo_w <= a;
              div_w <= b;
              cnt   <= '0;
              state <= ST_RUN;
            end
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          rem_w <= rem_next;
          quo_w <= {quo_w[WIDTH-2:0], q_bit};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            quotient    <= {quo_w[WIDTH-2:0], q_bit};
            remainder   <= rem_next;
            div_by_zero <= 1'b0;
            state       <= ST_DONE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : eight_bit_div_module

// File: tb/tb_eight_bit_div_module.sv
// Self-checking bench for eight_bit_div_module: directed cases plus a
// randomized back-to-back sweep against an arithmetic reference model.
module tb_eight_bit_div_module;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] prev_q   = '0;

  eight_bit_div_module #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; drives one request, waits for done and compares
  // latency, busy cycles and results with plain integer division.
  // Returns at the negedge inside the DONE cycle.
  task automatic do_div(input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    int bc;
    int eq, er, ed;
    if (y == 0) begin
      eq = (1 << W) - 1; er = x; ed = 1;
    end else begin
      eq = x / y; er = x % y; ed = 0;
    end
    start = 1'b1; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    n = 0; bc = 0;
    while (!done && n < 40) begin
      bc += int'(busy);
      if (n == 1) check($sformatf("hold_q %0d/%0d", x, y), quotient, prev_q);
      @(negedge clk);
      n++;
    end
    check($sformatf("latency %0d/%0d", x, y), n, (y == 0) ? 0 : W);
    check($sformatf("busy_cycles %0d/%0d", x, y), bc, (y == 0) ? 0 : W);
    check($sformatf("quotient %0d/%0d", x, y), quotient, eq);
    check($sformatf("remainder %0d/%0d", x, y), remainder, er);
    check($sformatf("dbz %0d/%0d", x, y), div_by_zero, ed);
    prev_q = W'(eq);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;

    #3;
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic divide and single-cycle done pulse with held results
    do_div(8'd200, 8'd7);
    @(negedge clk);
    check("done pulse width", done, 0);
    check("held quotient", quotient, 28);

    do_div(8'd5, 8'd9);
    do_div(8'd255, 8'd1);
    do_div(8'd255, 8'd255);
    do_div(8'd0, 8'd13);
    @(negedge clk);

    // Divide by zero skips RUN
    do_div(8'd77, 8'd0);
    @(negedge clk);
    check("dbz held after done", div_by_zero, 1);

    // Start during RUN is ignored; start during DONE is accepted
    start = 1'b1; a = 8'd100; b = 8'd3;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      start = (n == 2);
      a = 8'd9; b = 8'd2;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("ignored start latency", n, W);
    check("ignored start quotient", quotient, 33);
    check("ignored start remainder", remainder, 1);
    prev_q = 8'd33;
    do_div(8'd9, 8'd2);
    @(negedge clk);

    // Asynchronous reset mid-RUN
    start = 1'b1; a = 8'd200; b = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst quotient", quotient, 0);
    check("async rst remainder", remainder, 0);
    check("async rst busy", busy, 0);
    check("async rst done", done, 0);
    check("async rst dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      check("no done after abort", done, 0);
    end
    prev_q = '0;
    do_div(8'd50, 8'd5);

    // Random back-to-back sweep including zero divisors
    for (int i = 0; i < 1500; i++) begin
      logic [W-1:0] x, y;
      x = W'($urandom);
      y = (i % 16 == 0) ? '0 : W'($urandom);
      do_div(x, y);
    end
    @(negedge clk);
    check("idle after sweep", busy | done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_eight_bit_div_module
